// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data memory: mode states, access sizes,
// lane selection and load extension.
package dmem_pkg;

  typedef enum logic [1:0] {CLEAR, LOAD, RUN} state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Size 11 is reserved and always rejected.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = off[0];
      SZ_WORD: misaligned = (off != 2'b00);
      default: misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_en(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: lane_en = 4'b0001 << off;
      SZ_HALF: lane_en = off[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: lane_en = 4'b1111;
      default: lane_en = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] size,
                                           input logic [1:0] off, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: load_ext = {{24{~uns & b[7]}}, b};
      SZ_HALF: load_ext = {{16{~uns & h[15]}}, h};
      default: load_ext = word;
    endcase
  endfunction

endpackage

// File: rtl/dmem_if.sv
// CPU access port and UART programmer port of the data memory.
interface dmem_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              cpu_req;
  logic              cpu_we;
  logic [1:0]        cpu_size;
  logic              cpu_unsigned;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [31:0]       cpu_rdata;
  logic              cpu_rvalid;
  logic              cpu_misalign;
  logic              cpu_busy;
  logic              upg_start;
  logic              upg_wen_i;
  logic [ADDR_W-3:0] upg_adr_i;
  logic [31:0]       upg_dat_i;
  logic              upg_done_i;
  logic [ADDR_W-2:0] upg_count;

  modport master (
    output cpu_req, cpu_we, cpu_size, cpu_unsigned, cpu_addr, cpu_wdata,
    output upg_start, upg_wen_i, upg_adr_i, upg_dat_i, upg_done_i,
    input  cpu_rdata, cpu_rvalid, cpu_misalign, cpu_busy, upg_count
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_size, cpu_unsigned, cpu_addr, cpu_wdata,
    input  upg_start, upg_wen_i, upg_adr_i, upg_dat_i, upg_done_i,
    output cpu_rdata, cpu_rvalid, cpu_misalign, cpu_busy, upg_count
  );
endinterface

// File: rtl/dmem_bram.sv
// Single-port byte-lane RAM: per-lane write enables, registered read that
// only updates on a read enable so the output holds between loads.
module dmem_bram #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned IDX_W = 4
) (
  input  logic             clock,
  input  logic [IDX_W-1:0] addr,
  input  logic [3:0]       we,
  input  logic [31:0]      wdata,
  input  logic             re,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    for (int l = 0; l < 4; l++) begin
      if (we[l]) mem[addr][8*l +: 8] <= wdata[8*l +: 8];
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_loader.sv
// Data memory with clear sweep and UART word loader; a mode FSM decides
// whether the clear pointer, the loader or the CPU owns the RAM port.
module dmem_loader
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W         = 16,
  parameter int unsigned DEPTH          = 2 ** (ADDR_W - 2),
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input logic  clock,
  input logic  reset,
  dmem_if.slave bus
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = ADDR_W - 1;

  state_e           state_q;
  logic [IDX_W-1:0] clr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             busy_q, rvalid_q, misalign_q;
  logic             rd_zero_q, rd_uns_q;
  logic [1:0]       rd_size_q, rd_off_q;

  logic [IDX_W-1:0] cpu_idx, upg_idx, ram_addr;
  logic [3:0]       ram_we;
  logic [31:0]      ram_wdata, ram_rdata, st_data;
  logic             ram_re, cpu_go, cpu_mis, upg_ok;
  logic [1:0]       off;

  assign off     = bus.cpu_addr[1:0];
  // Word index aliases modulo DEPTH; loader addresses beyond DEPTH are dropped.
  assign cpu_idx = IDX_W'(32'(bus.cpu_addr[ADDR_W-1:2]) % DEPTH);
  assign upg_idx = IDX_W'(bus.upg_adr_i);
  assign upg_ok  = bus.upg_wen_i && (32'(bus.upg_adr_i) < DEPTH);
  assign cpu_go  = (state_q == RUN) && bus.cpu_req;
  assign cpu_mis = misaligned(bus.cpu_size, off);

  always_comb begin
    case (bus.cpu_size)
      SZ_BYTE: st_data = {4{bus.cpu_wdata[7:0]}};
      SZ_HALF: st_data = {2{bus.cpu_wdata[15:0]}};
      default: st_data = bus.cpu_wdata;
    endcase
  end

  always_comb begin
    ram_addr  = cpu_idx;
    ram_we    = 4'b0000;
    ram_wdata = st_data;
    ram_re    = 1'b0;
    case (state_q)
      CLEAR: begin
        ram_addr  = clr_ptr_q;
        ram_we    = 4'b1111;
        ram_wdata = 32'h0;
      end
      LOAD: begin
        ram_addr  = upg_idx;
        ram_we    = {4{upg_ok}};
        ram_wdata = bus.upg_dat_i;
      end
      RUN: begin
        ram_we = (cpu_go && bus.cpu_we && !cpu_mis) ? lane_en(bus.cpu_size, off) : 4'b0000;
        ram_re = cpu_go && !bus.cpu_we && !cpu_mis;
      end
      default: ;
    endcase
  end

  dmem_bram #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_bram (
    .clock (clock),
    .addr  (ram_addr),
    .we    (ram_we),
    .wdata (ram_wdata),
    .re    (ram_re),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= CLEAR_ON_RESET ? CLEAR : RUN;
      busy_q     <= CLEAR_ON_RESET;
      clr_ptr_q  <= '0;
      count_q    <= '0;
      rvalid_q   <= 1'b0;
      misalign_q <= 1'b0;
      rd_zero_q  <= 1'b1;
      rd_uns_q   <= 1'b0;
      rd_size_q  <= SZ_WORD;
      rd_off_q   <= 2'b00;
    end else begin
      rvalid_q   <= cpu_go && !bus.cpu_we;
      misalign_q <= cpu_go && cpu_mis;
      // Extension controls only advance on a load so cpu_rdata holds otherwise.
      if (cpu_go && !bus.cpu_we) begin
        rd_zero_q <= cpu_mis;
        rd_uns_q  <= bus.cpu_unsigned;
        rd_size_q <= bus.cpu_size;
        rd_off_q  <= off;
      end
      case (state_q)
        CLEAR: begin
          clr_ptr_q <= clr_ptr_q + 1'b1;
          if (clr_ptr_q == IDX_W'(DEPTH - 1)) begin
            state_q <= RUN;
            busy_q  <= 1'b0;
          end
        end
        LOAD: begin
          if (upg_ok && (count_q != '1)) count_q <= count_q + 1'b1;
          if (bus.upg_done_i) begin
            state_q <= RUN;
            busy_q  <= 1'b0;
          end
        end
        RUN: begin
          if (bus.upg_start) begin
            state_q <= LOAD;
            busy_q  <= 1'b1;
            count_q <= '0;
          end
        end
        default: begin
          state_q <= RUN;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cpu_rdata    = rd_zero_q ? 32'h0 : load_ext(ram_rdata, rd_size_q, rd_off_q, rd_uns_q);
  assign bus.cpu_rvalid   = rvalid_q;
  assign bus.cpu_misalign = misalign_q;
  assign bus.cpu_busy     = busy_q;
  assign bus.upg_count    = count_q;

endmodule
